// File: rtl/sign_mag_to_bcd.sv
// Sign-magnitude to packed BCD converter (sequential double-dabble).
// One magnitude bit is consumed per clock in OP; the result is held in the
// working registers until the next accepted start.
// Build option: define SM_NEGZERO_CLR_EN to report -0 as +0.
`timescale 1ns/1ps
module sign_mag_to_bcd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  // Counter must hold WIDTH-1; WIDTH-1 < 2^clog2(WIDTH) always.
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [WIDTH-2:0]      mag_q, mag_d;
  logic                  sign_q, sign_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic                  sign_in;

`ifdef SM_NEGZERO_CLR_EN
  // A zero magnitude always reports positive.
  assign sign_in = din[WIDTH-1] & (|din[WIDTH-2:0]);
`else
  assign sign_in = din[WIDTH-1];
`endif

  // Add-3 correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic for the FSM and the working registers.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_d   = din[WIDTH-2:0];
          sign_d  = sign_in;
          bcd_d   = '0;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = StOp;
        end
      end
      StOp: begin
        bcd_d = {bcd_adj[4*DIGITS-2:0], mag_q[WIDTH-2]};
        mag_d = {mag_q[WIDTH-3:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        // Last iteration is the one performed while the counter reads 1.
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and working registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = (state_q == StIdle);
  assign done_tick = (state_q == StDone);
  assign sign      = sign_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_sign_mag_to_bcd.sv
// Self-checking bench for sign_mag_to_bcd using an expected-result queue.
// Honours SM_NEGZERO_CLR_EN in its reference model.
`timescale 1ns/1ps
module tb_sign_mag_to_bcd;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic                clk;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    din;
  logic                ready;
  logic                done_tick;
  logic                sign;
  logic [4*DIGITS-1:0] bcd;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp;

  sign_mag_to_bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .ready     (ready),
    .done_tick (done_tick),
    .sign      (sign),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Decimal reference using integer arithmetic: {sign, d2, d1, d0}.
  function automatic logic [31:0] ref_out(input logic [7:0] v);
    int   m;
    logic s;
    m = int'(v[6:0]);
    s = v[7];
`ifdef SM_NEGZERO_CLR_EN
    if (m == 0) s = 1'b0;
`endif
    return {19'd0, s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Scoreboard: every done_tick pops one expected result.
  always @(negedge clk) begin
    if (done_tick) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'(done_tick), 32'd0);
      end else begin
        last_exp = sb_q.pop_front();
        check_val("result", {19'd0, sign, bcd}, last_exp);
      end
    end
  end

  // One conversion with latency/ready/done checks; called at a negedge.
  task automatic convert(input logic [7:0] v);
    int waited;
    int ndone;
    int dk;
    int nlow;
    waited = 0;
    while (!ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val("ready_wait", 32'(ready), 32'd1);
    check_val("hold", {19'd0, sign, bcd}, last_exp);
    start = 1'b1;
    din   = v;
    sb_q.push_back(ref_out(v));
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    dk    = -1;
    nlow  = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (done_tick) begin
        ndone++;
        dk = k;
      end
      if (!ready) nlow++;
    end
    check_val("done_count", 32'(ndone), 32'd1);
    check_val("done_latency", 32'(dk), 32'(WIDTH - 1));
    check_val("ready_low", 32'(nlow), 32'(WIDTH));
  endtask

  initial begin
    int first;
    int second;
    n_checks = 0;
    n_errors = 0;
    last_exp = 32'd0;
    reset = 1'b1;
    start = 1'b1;
    din   = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_done", 32'(done_tick), 32'd0);
    check_val("rst_out", {19'd0, sign, bcd}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    convert(8'h7F);
    convert(8'h85);
    convert(8'h80);
    convert(8'h00);

    // start held through OP/DONE: second word accepted only once ready returns
    start = 1'b1;
    din   = 8'h3F;
    sb_q.push_back(ref_out(8'h3F));
    sb_q.push_back(ref_out(8'h11));
    @(posedge clk);
    first  = -1;
    second = -1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) din = 8'h11;
      if (done_tick) begin
        if (first < 0) first = k;
        else second = k;
      end
      if (k == 8) check_val("held_ready", 32'(ready), 32'd1);
      if (k == 9) begin
        check_val("held_busy", 32'(ready), 32'd0);
        start = 1'b0;
      end
    end
    check_val("held_first", 32'(first), 32'd7);
    check_val("held_second", 32'(second), 32'd16);

    // Reset 3 cycles into OP aborts without a done_tick
    start = 1'b1;
    din   = 8'hD5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_ready", 32'(ready), 32'd1);
    check_val("abort_done", 32'(done_tick), 32'd0);
    check_val("abort_out", {19'd0, sign, bcd}, 32'd0);
    reset = 1'b0;
    last_exp = 32'd0;
    repeat (12) @(negedge clk);
    convert(8'h64);

    for (int i = 0; i < 256; i++) begin
      convert(8'(i));
    end

    repeat (3) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
